sd_crc_lanes: RTL and testbench
===============================

# sd_crc_lanes

Parametrised, multi-lane CRC engine for the SD data path. It computes one independent CRC per DAT line over a fixed-length block. In generate mode it appends the CRC bits after the data. In check mode it compares the received CRC tail against the computed value per lane. It sits between the SD bit-level serializer/deserializer and the block buffer, and replaces the single-lane, free-running CRC16 LFSR with a block-framed engine.

## Interface
Parameters:
- LANES, 4, number of DAT lines (1 or 4 in use)
- CRC_W, 16, CRC width (16 for data, 7 for command use)
- POLY, 16'h1021, generator polynomial without the implicit x^CRC_W term
- BLK_BITS, 1024, data bits per lane per block (512 bytes across 4 lanes)

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- START  in  1  one-cycle pulse: clear all lanes, begin a block
- MODE  in  1  sampled at START: 0 = generate, 1 = check
- DIN  in  LANES  one bit per lane
- DIN_VALID  in  1  bit-clock enable; DIN is consumed only when high
- DOUT  out  LANES  registered output bits (data pass-through, then CRC tail)
- DOUT_VALID  out  1  DOUT is valid this cycle
- BUSY  out  1  high from the cycle after START until DONE
- DONE  out  1  one-cycle pulse after the last tail bit
- CRC  out  LANES*CRC_W  computed CRC per lane (lane i at [i*CRC_W +: CRC_W]); held until next START
- CRC_ERR  out  LANES  per-lane mismatch flags (check mode); held until next START

## Operation
- States: IDLE, DATA, TAIL, DONE.
- IDLE → DATA on START. On entry: lane registers = 0, bit counter = 0, CRC_ERR = 0, MODE latched.
- DATA: on each DIN_VALID cycle, every lane i updates as follows.
  - inv = DIN[i] ^ crc_i[CRC_W-1]
  - crc_i = {crc_i[CRC_W-2:0], 1'b0} ^ (inv ? POLY : 0)
- DATA, generate mode: DOUT <= DIN and DOUT_VALID <= 1 on the same valid cycle.
- DATA, check mode: DOUT_VALID stays 0.
- DATA → TAIL on the valid cycle where counter == BLK_BITS-1. On that cycle the updated lane values are also copied into CRC. The counter resets to 0.
- TAIL: on each DIN_VALID cycle, lane registers shift left with zero fill. The counter runs to CRC_W-1.
  - Generate mode: DOUT <= lane MSBs, DOUT_VALID <= 1. DIN is ignored.
  - Check mode: CRC_ERR[i] |= DIN[i] ^ crc_i[CRC_W-1].
- TAIL → DONE after the CRC_W-th tail bit. DONE → IDLE unconditionally. The DONE output is high only in state DONE.
- Outside valid cycles nothing advances, and DOUT_VALID = 0.

## Timing
- Reset values: DOUT = 0, DOUT_VALID = 0, BUSY = 0, DONE = 0, CRC = 0, CRC_ERR = 0, state = IDLE, all lane registers 0.
- Latency: DOUT is DIN delayed by exactly 1 clock. The first tail bit appears 1 clock after the valid cycle that consumes the last data bit.
- Total block: BLK_BITS + CRC_W valid cycles, then 1 DONE cycle.
- START in any state, including mid-block, aborts and restarts. Precedence is START > DIN_VALID: a bit presented in the START cycle is not consumed.
- START during DONE: DONE still pulses, and the state goes to DATA, not IDLE.
- DIN_VALID low for any number of cycles: the state is frozen.
- Async RST mid-block returns to reset values immediately, with no DONE pulse.
- Counter width: $clog2(BLK_BITS) bits, with no wrap beyond BLK_BITS-1.

## Structure
- Package sd_crc_pkg holds the following.
  - The state enum.
  - Constants SD_CRC16_POLY = 16'h1021, SD_CRC7_POLY = 7'h09, SD_BLK_BITS_4L = 1024, SD_BLK_BITS_1L = 4096.
- Sub-module sd_crc_lfsr: one lane, parameters CRC_W/POLY, ports CLK, RST, CLR, EN, SHIFT, BITVAL, CRC. It is instantiated LANES times by generate.
- The FSM, counters, DOUT mux and error accumulation live in sd_crc_lanes.

## Test plan
- LANES=1, BLK_BITS=4096, generate mode, 512 bytes of 0xFF with no gaps → CRC = 16'h7FA1. DOUT carries 4096 ones followed by 0111_1111_1010_0001. DONE pulses at valid cycle 4112 + 1.
- LANES=1, BLK_BITS=72, ASCII "123456789" MSB-first → CRC = 16'h31C3.
- LANES=4, BLK_BITS=1024, check mode, all-zero data and a zero tail → every lane CRC = 0, CRC_ERR = 4'b0000.
- Same as the previous scenario, but flip tail bit 5 on lane 2 → CRC_ERR = 4'b0100. Other lanes stay clear.
- Generate mode, DIN_VALID random 30% duty → CRC and DOUT sequence identical to the gap-free run. DOUT_VALID count = BLK_BITS + CRC_W.
- START at data bit 500, then RST asserted mid-tail → the abort restarts the count (BUSY stays 1). After RST: all outputs 0, no DONE pulse.

Source files
------------

// File: rtl/sd_crc_pkg.sv
// sd_crc_pkg: shared definitions for the SD multi-lane CRC engine.
//   - sd_crc_state_e : block framing state (IDLE, DATA, TAIL, DONE)
//   - SD_CRC16_POLY / SD_CRC7_POLY : SD data and command generator polynomials
//   - SD_BLK_BITS_4L / SD_BLK_BITS_1L : data bits per lane for a 512-byte block
package sd_crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2,
        ST_DONE = 2'd3
    } sd_crc_state_e;

    localparam logic [15:0] SD_CRC16_POLY  = 16'h1021;
    localparam logic [6:0]  SD_CRC7_POLY   = 7'h09;
    localparam int unsigned SD_BLK_BITS_4L = 1024;
    localparam int unsigned SD_BLK_BITS_1L = 4096;

endpackage

// File: rtl/sd_crc_lfsr.sv
// sd_crc_lfsr: one lane of the SD CRC engine (MSB-first, zero-initialised LFSR).
// Ports:
//   CLK, RST  clock, asynchronous active-high reset
//   CLR       synchronous clear to zero (block start)
//   EN        advance one step this cycle
//   SHIFT     0: absorb BITVAL into the CRC, 1: shift left with zero fill (tail out)
//   BITVAL    input data bit
//   CRC       current register value
module sd_crc_lfsr
    import sd_crc_pkg::*;
#(
    parameter int unsigned      CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = SD_CRC16_POLY
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             EN,
    input  logic             SHIFT,
    input  logic             BITVAL,
    output logic [CRC_W-1:0] CRC
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CRC <= '0;
        end else if (CLR) begin
            CRC <= '0;
        end else if (EN) begin
            if (SHIFT) begin
                CRC <= {CRC[CRC_W-2:0], 1'b0};
            end else begin
                CRC <= {CRC[CRC_W-2:0], 1'b0} ^ ((BITVAL ^ CRC[CRC_W-1]) ? POLY : '0);
            end
        end
    end

endmodule

// File: rtl/sd_crc_lanes.sv
// sd_crc_lanes: block-framed, per-DAT-line CRC engine for the SD data path.
// Generate mode passes data through and appends each lane's CRC; check mode
// compares the received tail against the computed CRC per lane.
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   START        one-cycle pulse: clear lanes and begin a block (aborts any block)
//   MODE         sampled at START: 0 = generate, 1 = check
//   DIN          one bit per lane
//   DIN_VALID    bit-clock enable
//   DOUT         registered output bits (data, then CRC tail)
//   DOUT_VALID   DOUT valid this cycle
//   BUSY         block in progress (DATA or TAIL)
//   DONE         one-cycle pulse after the last tail bit
//   CRC          per-lane CRC, lane i at [i*CRC_W +: CRC_W]
//   CRC_ERR      per-lane tail mismatch flags (check mode)
module sd_crc_lanes
    import sd_crc_pkg::*;
#(
    parameter int unsigned      LANES    = 4,
    parameter int unsigned      CRC_W    = 16,
    parameter logic [CRC_W-1:0] POLY     = SD_CRC16_POLY,
    parameter int unsigned      BLK_BITS = SD_BLK_BITS_4L
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   MODE,
    input  logic [LANES-1:0]       DIN,
    input  logic                   DIN_VALID,
    output logic [LANES-1:0]       DOUT,
    output logic                   DOUT_VALID,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [LANES*CRC_W-1:0] CRC,
    output logic [LANES-1:0]       CRC_ERR
);

    localparam int unsigned      CNT_W     = (BLK_BITS > 1) ? $clog2(BLK_BITS) : 1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(BLK_BITS - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(CRC_W - 1);

    sd_crc_state_e          state;
    logic [CNT_W-1:0]       cnt;
    logic                   mode_q;
    logic                   active;
    logic                   step;
    logic [LANES*CRC_W-1:0] lane_crc;
    logic [LANES*CRC_W-1:0] lane_next;
    logic [LANES-1:0]       lane_msb;

    assign active = (state == ST_DATA) || (state == ST_TAIL);
    // START wins over DIN_VALID: a bit presented with START is not consumed.
    assign step   = DIN_VALID && !START && active;
    assign BUSY   = active;
    assign DONE   = (state == ST_DONE);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sd_crc_lfsr #(
            .CRC_W (CRC_W),
            .POLY  (POLY)
        ) u_lfsr (
            .CLK    (CLK),
            .RST    (RST),
            .CLR    (START),
            .EN     (step),
            .SHIFT  (state == ST_TAIL),
            .BITVAL (DIN[i]),
            .CRC    (lane_crc[i*CRC_W +: CRC_W])
        );

        assign lane_msb[i] = lane_crc[i*CRC_W + CRC_W - 1];
        // Value the lane takes on this edge; lets CRC capture the final data
        // step in the same cycle the lane register does.
        assign lane_next[i*CRC_W +: CRC_W] =
            {lane_crc[i*CRC_W +: CRC_W-1], 1'b0} ^ ((DIN[i] ^ lane_msb[i]) ? POLY : '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            mode_q     <= 1'b0;
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
            CRC        <= '0;
            CRC_ERR    <= '0;
        end else begin
            DOUT_VALID <= 1'b0;
            if (START) begin
                state   <= ST_DATA;
                cnt     <= '0;
                mode_q  <= MODE;
                CRC     <= '0;
                CRC_ERR <= '0;
            end else begin
                case (state)
                    ST_DATA: begin
                        if (DIN_VALID) begin
                            if (!mode_q) begin
                                DOUT       <= DIN;
                                DOUT_VALID <= 1'b1;
                            end
                            if (cnt == DATA_LAST) begin
                                CRC   <= lane_next;
                                cnt   <= '0;
                                state <= ST_TAIL;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    ST_TAIL: begin
                        if (DIN_VALID) begin
                            if (!mode_q) begin
                                DOUT       <= lane_msb;
                                DOUT_VALID <= 1'b1;
                            end else begin
                                CRC_ERR <= CRC_ERR | (DIN ^ lane_msb);
                            end
                            if (cnt == TAIL_LAST) begin
                                cnt   <= '0;
                                state <= ST_DONE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_crc_lanes.sv
// tb_sd_crc_lanes: randomized, scoreboard-checked bench for sd_crc_lanes
// (LANES=4, CRC_W=16, BLK_BITS=1024). Expected CRCs come from polynomial long
// division of the zero-augmented message.
module tb_sd_crc_lanes;
    localparam int BLK  = 1024;
    localparam int CW   = 16;
    localparam logic [15:0] GPOLY = 16'h1021;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        MODE;
    logic [3:0]  DIN;
    logic        DIN_VALID;
    logic [3:0]  DOUT;
    logic        DOUT_VALID;
    logic        BUSY;
    logic        DONE;
    logic [63:0] CRC;
    logic [3:0]  CRC_ERR;

    sd_crc_lanes #(
        .LANES    (4),
        .CRC_W    (16),
        .POLY     (16'h1021),
        .BLK_BITS (1024)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .MODE       (MODE),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .CRC        (CRC),
        .CRC_ERR    (CRC_ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int dv_cnt = 0;

    logic [3:0]  data [BLK];
    logic [15:0] tail [4];
    logic [3:0]  exp_q [$];
    logic [67:0] res_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Remainder of M(x)*x^16 mod G(x) by long division over the augmented message.
    function automatic logic [15:0] ref_crc(input int lane);
        logic [15:0] r = '0;
        logic top;
        logic b;
        for (int k = 0; k < BLK + CW; k++) begin
            b   = (k < BLK) ? data[k][lane] : 1'b0;
            top = r[15];
            r   = {r[14:0], b};
            if (top) r = r ^ GPOLY;
        end
        return r;
    endfunction

    // Monitor: pops expectations whenever the DUT presents output.
    always @(negedge CLK) begin
        if (!RST) begin
            if (DOUT_VALID) begin
                dv_cnt++;
                if (exp_q.size() == 0) chk("dout_unexpected_valid", {63'd0, DOUT_VALID}, 64'd0);
                else chk("dout", {60'd0, DOUT}, {60'd0, exp_q.pop_front()});
            end
            if (DONE) begin
                if (res_q.size() == 0) begin
                    chk("done_unexpected", {63'd0, DONE}, 64'd0);
                end else begin
                    logic [67:0] e;
                    e = res_q.pop_front();
                    chk("crc", CRC, e[63:0]);
                    chk("crc_err", {60'd0, CRC_ERR}, {60'd0, e[67:64]});
                end
            end
        end
    end

    task automatic gap(input int duty);
        while ($urandom_range(99) >= duty) begin
            DIN_VALID = 1'b0;
            DIN       = 4'($urandom);
            @(posedge CLK); #1;
        end
    endtask

    // Caller is at posedge+#1. START is raised immediately, with a random bit
    // presented alongside it that must not be consumed.
    task automatic send_block(input bit mode, input int duty, input int n_data, input int n_tail);
        logic [63:0] ecrc;
        logic [3:0]  eerr;
        logic [3:0]  tb_bits;
        logic [3:0]  etb;
        for (int l = 0; l < 4; l++) begin
            ecrc[l*16 +: 16] = ref_crc(l);
            eerr[l] = mode && (tail[l] != ecrc[l*16 +: 16]);
        end
        START = 1'b1; MODE = mode; DIN_VALID = 1'b1; DIN = 4'($urandom);
        @(posedge CLK); #1;
        START = 1'b0; MODE = 1'($urandom);
        chk("busy_after_start", {63'd0, BUSY}, 64'd1);
        dv_cnt = 0;
        for (int b = 0; b < n_data; b++) begin
            gap(duty);
            DIN_VALID = 1'b1;
            DIN = data[b];
            if (!mode) exp_q.push_back(data[b]);
            @(posedge CLK); #1;
        end
        for (int k = 0; k < n_tail; k++) begin
            gap(duty);
            for (int l = 0; l < 4; l++) begin
                tb_bits[l] = mode ? tail[l][15-k] : 1'($urandom);
                etb[l]     = ecrc[l*16 + 15 - k];
            end
            DIN_VALID = 1'b1;
            DIN = tb_bits;
            if (!mode) exp_q.push_back(etb);
            @(posedge CLK); #1;
        end
        DIN_VALID = 1'b0;
        if (n_data == BLK && n_tail == CW) begin
            res_q.push_back({eerr, ecrc});
            chk("done_pulse", {63'd0, DONE}, 64'd1);
            chk("busy_in_done", {63'd0, BUSY}, 64'd0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 5 && (res_q.size() != 0 || exp_q.size() != 0); i++) begin
            @(posedge CLK); #1;
        end
        chk("queues_drained", 64'(res_q.size() + exp_q.size()), 64'd0);
        @(posedge CLK); #1;
        chk("done_one_cycle", {63'd0, DONE}, 64'd0);
    endtask

    task automatic rand_data();
        for (int b = 0; b < BLK; b++) data[b] = 4'($urandom);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        string msg;
        byte   ch;
        RST = 1'b1; START = 1'b0; MODE = 1'b0; DIN = '0; DIN_VALID = 1'b0;
        for (int l = 0; l < 4; l++) tail[l] = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_dout", {60'd0, DOUT}, 64'd0);
        chk("rst_dout_valid", {63'd0, DOUT_VALID}, 64'd0);
        chk("rst_busy", {63'd0, BUSY}, 64'd0);
        chk("rst_done", {63'd0, DONE}, 64'd0);
        chk("rst_crc", CRC, 64'd0);
        chk("rst_crc_err", {60'd0, CRC_ERR}, 64'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Lane 0: zero prefix then "123456789" MSB-first (zero prefix leaves the CRC unchanged).
        rand_data();
        for (int b = 0; b < BLK; b++) data[b][0] = 1'b0;
        msg = "123456789";
        for (int c = 0; c < 9; c++) begin
            ch = msg[c];
            for (int k = 0; k < 8; k++) data[BLK - 72 + c*8 + k][0] = ch[7-k];
        end
        send_block(1'b0, 100, BLK, CW);
        drain();
        chk("crc_123456789", {48'd0, CRC[15:0]}, 64'h31C3);

        // Gap-free then 30% duty on the same data; second START lands in DONE.
        rand_data();
        send_block(1'b0, 100, BLK, CW);
        send_block(1'b0, 30, BLK, CW);
        drain();
        chk("dout_valid_count", 64'(dv_cnt), 64'(BLK + CW));

        // Check mode: all-zero data, zero tail, then one flipped tail bit on lane 2.
        for (int b = 0; b < BLK; b++) data[b] = '0;
        for (int l = 0; l < 4; l++) tail[l] = '0;
        send_block(1'b1, 100, BLK, CW);
        drain();
        chk("zero_crc_err", {60'd0, CRC_ERR}, 64'd0);
        tail[2] = 16'h0400;
        send_block(1'b1, 100, BLK, CW);
        drain();
        chk("flip_lane2_err", {60'd0, CRC_ERR}, 64'h4);

        // Check mode, random data, correct tails with random corruption.
        repeat (2) begin
            rand_data();
            for (int l = 0; l < 4; l++) tail[l] = ref_crc(l) ^ (($urandom % 2) ? 16'($urandom) : 16'h0);
            send_block(1'b1, 50, BLK, CW);
            drain();
        end

        // Abort at data bit 500 with a new START, then a full block.
        rand_data();
        send_block(1'b0, 70, 500, 0);
        chk("busy_before_abort", {63'd0, BUSY}, 64'd1);
        rand_data();
        send_block(1'b0, 70, BLK, CW);
        drain();

        // Async reset in the middle of the tail.
        rand_data();
        send_block(1'b0, 100, BLK, 5);
        @(negedge CLK); #1;
        RST = 1'b1;
        #1;
        chk("arst_dout", {60'd0, DOUT}, 64'd0);
        chk("arst_dout_valid", {63'd0, DOUT_VALID}, 64'd0);
        chk("arst_busy", {63'd0, BUSY}, 64'd0);
        chk("arst_done", {63'd0, DONE}, 64'd0);
        chk("arst_crc", CRC, 64'd0);
        chk("arst_crc_err", {60'd0, CRC_ERR}, 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (30) @(posedge CLK);
        #1;
        chk("arst_no_done_busy", {62'd0, DONE, BUSY}, 64'd0);
        chk("arst_queues", 64'(res_q.size() + exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
